uart_tx: RTL and testbench

Serial UART transmitter for the cpu6 SoC: the transmit-side counterpart of the existing `u_uart.urx` receiver. It accepts bytes from the SoC peripheral bus into a small FIFO and shifts each one out on `txd` as an 8N1 frame, optionally with a parity bit. Status outputs let the core poll for space, completion and overrun. It sits inside `u_uart` next to `urx` and shares its baud configuration.

---
 rtl/uart_tx.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter with a small write FIFO, 8N1 framing.
// Define CPU6_UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx #(
   parameter int CLK_DIV    = 434,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   input  logic       tx_ovr_clr,
   output logic       txd,
   output logic       tx_full,
   output logic       tx_empty,
   output logic       tx_busy,
   output logic       tx_ovr
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef CPU6_UART_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;

   state_t        r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit_idx;
   logic [7:0]    r_shift;
`ifdef CPU6_UART_TX_PARITY_EN
   logic          r_parity;
`endif

   logic          w_push;
   logic          w_pop;
   logic          w_baud_last;
   logic          w_idle_next;
   logic [CW-1:0] w_count_next;

   // A full FIFO refuses the write even if the FSM pops on the same edge.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned
      // (which would infer a latch).
      w_count_next = r_count;
      w_baud_last  = (r_baud == BAUD_LAST);
      w_push       = tx_wr && !tx_full;
      w_pop        = !tx_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last));
      w_idle_next  = !w_pop &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last));
      if (w_push && !w_pop) begin
         w_count_next = r_count + CW'(1);
      end else if (w_pop && !w_push) begin
         w_count_next = r_count - CW'(1);
      end
   end

   // NOTE: the storage array has no reset; the pointers and count alone decide
   // which entries are valid, so clearing the data would buy nothing.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= tx_data;
      end
   end

   // NOTE: all clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_count  <= '0;
         tx_full  <= 1'b0;
         tx_empty <= 1'b1;
         tx_busy  <= 1'b0;
         tx_ovr   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         r_count  <= w_count_next;
         tx_full  <= (w_count_next == COUNT_FULL);
         tx_empty <= (w_count_next == '0);
         tx_busy  <= !w_idle_next || (w_count_next != '0);
         if (tx_wr && tx_full) begin
            tx_ovr <= 1'b1;
         end else if (tx_ovr_clr) begin
            tx_ovr <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
`ifdef CPU6_UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
         txd       <= 1'b1;
      end else if (w_pop) begin
         // Pop from IDLE or at the end of STOP: both start a new frame at once.
         r_state <= S_START;
         r_baud  <= '0;
         r_shift <= r_mem[r_rptr];
`ifdef CPU6_UART_TX_PARITY_EN
         r_parity <= ^r_mem[r_rptr];
`endif
         txd     <= 1'b0;
      end else begin
         r_baud <= w_baud_last ? '0 : r_baud + BW'(1);
         case (r_state)
            S_IDLE: begin
               r_baud <= '0;
               txd    <= 1'b1;
            end
            S_START: begin
               if (w_baud_last) begin
                  r_state   <= S_DATA;
                  r_bit_idx <= '0;
                  txd       <= r_shift[0];
               end
            end
            S_DATA: begin
               if (w_baud_last) begin
                  if (r_bit_idx == 3'd7) begin
`ifdef CPU6_UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     txd     <= r_parity;
`else
                     r_state <= S_STOP;
                     txd     <= 1'b1;
`endif
                  end else begin
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_shift   <= r_shift >> 1;
                     txd       <= r_shift[1];
                  end
               end
            end
`ifdef CPU6_UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_baud_last) begin
                  r_state <= S_STOP;
                  txd     <= 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_baud_last) begin
                  r_state <= S_IDLE;
                  txd     <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               txd     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random stimulus for uart_tx, with a line decoder
// that turns txd back into frames compared against a bit-level frame model.
module tb_uart_tx;

   localparam int DIV   = 4;
   localparam int DEPTH = 4;
`ifdef CPU6_UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * DIV;

   typedef struct {
      logic [NB-1:0] bits;
      logic          stable;
      int            start;
   } frame_t;

   logic       clk;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_wr;
   logic       tx_ovr_clr;
   logic       txd;
   logic       tx_full;
   logic       tx_empty;
   logic       tx_busy;
   logic       tx_ovr;

   int          n_checks;
   int          n_errors;
   int          cyc;
   int          busy_fall;
   frame_t      rxq[$];
   logic [NB-1:0] mon_bits;
   logic        mon_stable;
   int          mon_start;

   uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .tx_data    (tx_data),
      .tx_wr      (tx_wr),
      .tx_ovr_clr (tx_ovr_clr),
      .txd        (txd),
      .tx_full    (tx_full),
      .tx_empty   (tx_empty),
      .tx_busy    (tx_busy),
      .tx_ovr     (tx_ovr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Expected line image of one frame, first bit in the LSB.
   function automatic logic [NB-1:0] model_bits(input logic [7:0] b);
`ifdef CPU6_UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b1, b, 1'b0};
`endif
   endfunction

   // Line decoder: a falling txd opens a frame of NB bits, DIV samples each.
   initial begin : monitor
      int   pos;
      logic prev_busy;
      pos       = -1;
      prev_busy = 1'b0;
      busy_fall = -1;
      forever begin
         @(negedge clk);
         if (reset) begin
            pos = -1;
         end else if (pos < 0) begin
            if (txd === 1'b0) begin
               mon_bits   = '0;
               mon_stable = 1'b1;
               mon_start  = cyc;
               pos        = 1;
            end
         end else begin
            if (pos % DIV == 0) mon_bits[pos / DIV] = txd;
            else if (txd !== mon_bits[pos / DIV]) mon_stable = 1'b0;
            pos++;
            if (pos == FRAME) begin
               rxq.push_back('{bits: mon_bits, stable: mon_stable, start: mon_start});
               pos = -1;
            end
         end
         if (prev_busy && !tx_busy) busy_fall = cyc;
         prev_busy = tx_busy;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      tx_data = b;
      tx_wr   = 1'b1;
   endtask

   task automatic idle();
      @(negedge clk);
      tx_wr = 1'b0;
   endtask

   task automatic get_frame(input string tag, output frame_t f);
      int w;
      w = 0;
      while (rxq.size() == 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_timeout"}, 32'(rxq.size() != 0), 32'd1);
      if (rxq.size() != 0) begin
         f = rxq.pop_front();
      end else begin
         f.bits   = '0;
         f.stable = 1'b0;
         f.start  = 0;
      end
   endtask

   task automatic expect_frame(input string tag, input logic [7:0] b, output frame_t f);
      get_frame(tag, f);
      check({tag, "_bits"}, 32'(f.bits), 32'(model_bits(b)));
      check({tag, "_stable"}, 32'(f.stable), 32'd1);
   endtask

   initial begin
      frame_t     f1;
      frame_t     f2;
      logic [7:0] b;
      logic [7:0] exp_q[$];
      int         w;
      int         low;

      n_checks   = 0;
      n_errors   = 0;
      reset      = 1'b1;
      tx_wr      = 1'b0;
      tx_data    = 8'h00;
      tx_ovr_clr = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("rst_txd",   32'(txd),      32'd1);
      check("rst_full",  32'(tx_full),  32'd0);
      check("rst_empty", 32'(tx_empty), 32'd1);
      check("rst_busy",  32'(tx_busy),  32'd0);
      check("rst_ovr",   32'(tx_ovr),   32'd0);

      // Single frame with write-to-start latency.
      push(8'h55);
      idle();
      check("wr_empty", 32'(tx_empty), 32'd0);
      check("wr_busy",  32'(tx_busy),  32'd1);
      check("wr_txd",   32'(txd),      32'd1);
      @(negedge clk);
      check("pop_txd",   32'(txd),      32'd0);
      check("pop_empty", 32'(tx_empty), 32'd1);
      expect_frame("f55", 8'h55, f1);
      @(negedge clk);
      check("f55_busy_len", 32'(busy_fall - f1.start), 32'(FRAME));
      check("f55_busy_low", 32'(tx_busy), 32'd0);

      // Back-to-back frames with no idle gap.
      push(8'hA5);
      push(8'h3C);
      idle();
      expect_frame("fa5", 8'hA5, f1);
      expect_frame("f3c", 8'h3C, f2);
      check("b2b_gap", 32'(f2.start - f1.start), 32'(FRAME));
      @(negedge clk);
      check("b2b_busy_len", 32'(busy_fall - f1.start), 32'(2 * FRAME));

      // Overrun: the sixth write hits a full FIFO.
      for (int i = 1; i <= 5; i++) push(8'(i));
      @(negedge clk);
      check("ovr_full", 32'(tx_full), 32'd1);
      check("ovr_pre",  32'(tx_ovr),  32'd0);
      tx_data = 8'h06;
      tx_wr   = 1'b1;
      idle();
      check("ovr_set", 32'(tx_ovr), 32'd1);
      for (int i = 1; i <= 5; i++) expect_frame($sformatf("ovr_f%0d", i), 8'(i), f1);
      repeat (60) @(negedge clk);
      check("ovr_extra", 32'(rxq.size()), 32'd0);
      check("ovr_sticky", 32'(tx_ovr), 32'd1);
      @(negedge clk);
      tx_ovr_clr = 1'b1;
      @(negedge clk);
      tx_ovr_clr = 1'b0;
      check("ovr_clr", 32'(tx_ovr), 32'd0);

`ifdef CPU6_UART_TX_PARITY_EN
      push(8'h07);
      idle();
      expect_frame("par07", 8'h07, f1);
      check("par07_bit", 32'(f1.bits[9]), 32'd1);
      @(negedge clk);
      check("par07_len", 32'(busy_fall - f1.start), 32'd44);
      push(8'h03);
      idle();
      expect_frame("par03", 8'h03, f1);
      check("par03_bit", 32'(f1.bits[9]), 32'd0);
      @(negedge clk);
      check("par03_len", 32'(busy_fall - f1.start), 32'd44);
`endif

      // Pointer wrap-around at low occupancy.
      for (int i = 0; i < 10; i++) begin
         push(8'h10 + 8'(i));
         idle();
         repeat (34) @(negedge clk);
      end
      for (int i = 0; i < 10; i++) expect_frame($sformatf("wrap%0d", i), 8'h10 + 8'(i), f1);
      check("wrap_ovr", 32'(tx_ovr), 32'd0);

      // Random bytes with random gaps, written only while space is reported.
      for (int i = 0; i < 12; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         w = 0;
         while (tx_full && w < 200) begin
            @(negedge clk);
            w++;
         end
         push(b);
         idle();
         repeat ($urandom_range(0, 50)) @(negedge clk);
      end
      for (int i = 0; i < 12; i++) expect_frame($sformatf("rnd%0d", i), exp_q[i], f1);
      check("rnd_ovr", 32'(tx_ovr), 32'd0);
      check("rnd_drain", 32'(rxq.size()), 32'd0);

      // Reset during data bit 3 of the first of two queued frames.
      push(8'hFF);
      push(8'h00);
      idle();
      check("rmf_start", 32'(txd), 32'd0);
      repeat (17) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rmf_txd",   32'(txd),      32'd1);
      check("rmf_full",  32'(tx_full),  32'd0);
      check("rmf_empty", 32'(tx_empty), 32'd1);
      check("rmf_busy",  32'(tx_busy),  32'd0);
      check("rmf_ovr",   32'(tx_ovr),   32'd0);
      @(negedge clk);
      reset = 1'b0;
      low = 0;
      repeat (100) begin
         @(negedge clk);
         if (txd !== 1'b1) low++;
      end
      check("rmf_quiet", 32'(low), 32'd0);
      check("rmf_frames", 32'(rxq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
